// File: rtl/ccr_branch_eval.sv
// CVNZ condition-code register plus branch evaluator: accept -> EVAL -> RESP, response valid two edges after accept.
// Holds the response stable under resp_ready backpressure; req_ready is high only in IDLE.
module ccr_branch_eval #(
    parameter int          addr_w = 8,
    parameter int          cnt_w  = 8,
    parameter logic [3:0]  c_mask = 4'b1000,
    parameter logic [3:0]  v_mask = 4'b0100,
    parameter logic [3:0]  n_mask = 4'b0010,
    parameter logic [3:0]  z_mask = 4'b0001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ccr_we,
    input  logic [3:0]        ccr_in,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_cond,
    input  logic [addr_w-1:0] req_pc,
    input  logic [addr_w-1:0] req_off,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_taken,
    output logic [addr_w-1:0] resp_target,
    output logic [3:0]        ccr_out,
    output logic [cnt_w-1:0]  taken_cnt
);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    state_t              state_q;
    logic [3:0]          ccr_q;
    logic [3:0]          cond_q;
    logic [addr_w-1:0]   pc_q;
    logic [addr_w-1:0]   off_q;
    logic                resp_valid_q;
    logic                resp_taken_q;
    logic [addr_w-1:0]   resp_target_q;
    logic [cnt_w-1:0]    taken_cnt_q;

    logic                flag_c, flag_v, flag_n, flag_z;
    logic                resp_taken_d;
    logic [addr_w-1:0]   resp_target_d;

    assign flag_c = |(ccr_q & c_mask);
    assign flag_v = |(ccr_q & v_mask);
    assign flag_n = |(ccr_q & n_mask);
    assign flag_z = |(ccr_q & z_mask);

    always_comb begin
        resp_taken_d = 1'b0;
        unique case (cond_q)
            4'h0: resp_taken_d = 1'b1;
            4'h1: resp_taken_d = 1'b0;
            4'h2: resp_taken_d = !flag_c && !flag_z;
            4'h3: resp_taken_d = flag_c || flag_z;
            4'h4: resp_taken_d = !flag_c;
            4'h5: resp_taken_d = flag_c;
            4'h6: resp_taken_d = !flag_z;
            4'h7: resp_taken_d = flag_z;
            4'h8: resp_taken_d = !flag_v;
            4'h9: resp_taken_d = flag_v;
            4'hA: resp_taken_d = !flag_n;
            4'hB: resp_taken_d = flag_n;
            4'hC: resp_taken_d = (flag_n == flag_v);
            4'hD: resp_taken_d = (flag_n != flag_v);
            4'hE: resp_taken_d = !flag_z && (flag_n == flag_v);
            4'hF: resp_taken_d = flag_z || (flag_n != flag_v);
            default: resp_taken_d = 1'b0;
        endcase
        // Equal-width add: the offset acts as two's complement, carry out dropped.
        resp_target_d = resp_taken_d ? (pc_q + off_q)
                                     : (pc_q + {{(addr_w-1){1'b0}}, 1'b1});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ccr_q         <= '0;
            cond_q        <= '0;
            pc_q          <= '0;
            off_q         <= '0;
            resp_valid_q  <= 1'b0;
            resp_taken_q  <= 1'b0;
            resp_target_q <= '0;
            taken_cnt_q   <= '0;
        end else begin
            if (ccr_we) begin
                ccr_q <= ccr_in;
            end
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        cond_q  <= req_cond;
                        pc_q    <= req_pc;
                        off_q   <= req_off;
                        state_q <= EVAL;
                    end
                end
                EVAL: begin
                    resp_taken_q  <= resp_taken_d;
                    resp_target_q <= resp_target_d;
                    resp_valid_q  <= 1'b1;
                    state_q       <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        if (resp_taken_q && (taken_cnt_q != {cnt_w{1'b1}})) begin
                            taken_cnt_q <= taken_cnt_q + {{(cnt_w-1){1'b0}}, 1'b1};
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready   = rst_n && (state_q == IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_taken  = resp_taken_q;
    assign resp_target = resp_target_q;
    assign ccr_out     = ccr_q;
    assign taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_ccr_branch_eval.sv
// Scoreboard bench for ccr_branch_eval with a 2-bit taken counter to reach saturation quickly.
module tb_ccr_branch_eval;

    localparam int AW = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ccr_we;
    logic [3:0]    ccr_in;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_cond;
    logic [AW-1:0] req_pc;
    logic [AW-1:0] req_off;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_taken;
    logic [AW-1:0] resp_target;
    logic [3:0]    ccr_out;
    logic [CW-1:0] taken_cnt;

    always #5 clk = ~clk;

    ccr_branch_eval #(.addr_w(AW), .cnt_w(CW)) dut (
        .clk(clk), .rst_n(rst_n), .ccr_we(ccr_we), .ccr_in(ccr_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_cond(req_cond),
        .req_pc(req_pc), .req_off(req_off), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_taken(resp_taken), .resp_target(resp_target),
        .ccr_out(ccr_out), .taken_cnt(taken_cnt)
    );

    typedef struct packed {
        logic          taken;
        logic [AW-1:0] target;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    int            n_chk  = 0;
    int            n_fail = 0;
    logic [3:0]    model_ccr = 4'b0;
    logic [CW-1:0] model_cnt = '0;

    // Reference evaluator with C,V,N,Z at bits 3,2,1,0.
    function automatic exp_t ref_resp(input logic [3:0] cond, input logic [3:0] ccr,
                                      input logic [AW-1:0] pc, input logic [AW-1:0] off);
        logic c, v, n, z, t;
        exp_t r;
        c = ccr[3]; v = ccr[2]; n = ccr[1]; z = ccr[0];
        case (cond)
            4'h0: t = 1'b1;        4'h1: t = 1'b0;
            4'h2: t = ~c & ~z;     4'h3: t = c | z;
            4'h4: t = ~c;          4'h5: t = c;
            4'h6: t = ~z;          4'h7: t = z;
            4'h8: t = ~v;          4'h9: t = v;
            4'hA: t = ~n;          4'hB: t = n;
            4'hC: t = ~(n ^ v);    4'hD: t = n ^ v;
            4'hE: t = ~z & ~(n ^ v);
            default: t = z | (n ^ v);
        endcase
        r.taken  = t;
        r.target = t ? AW'(pc + off) : AW'(pc + 8'd1);
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic handshake;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        if (e.taken && model_cnt != '1) model_cnt = model_cnt + 1'b1;
    endtask

    task automatic write_ccr(input logic [3:0] v);
        ccr_we = 1'b1; ccr_in = v;
        tick();
        ccr_we = 1'b0;
        model_ccr = v;
    endtask

    // Drives one request (optionally with a same-edge CCR write) and pushes its expectation.
    task automatic send(input logic [3:0] cond, input logic [AW-1:0] pc, input logic [AW-1:0] off,
                        input logic we, input logic [3:0] wv);
        int budget;
        req_valid = 1'b1; req_cond = cond; req_pc = pc; req_off = off;
        ccr_we = we; ccr_in = wv;
        budget = 0;
        while (!req_ready && budget < 20) begin
            tick();
            budget++;
        end
        tick();
        req_valid = 1'b0; ccr_we = 1'b0;
        if (we) model_ccr = wv;
        sb.push_back(ref_resp(cond, model_ccr, pc, off));
    endtask

    task automatic wait_resp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(); tick();
        n_chk++; if (ccr_out !== 4'b0) begin n_fail++; $display("FAIL reset_ccr got %b want 0000", ccr_out); end
        n_chk++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        n_chk++; if (taken_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", taken_cnt); end
        n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
        rst_n = 1'b1;
        #1;
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_req_ready got %b want 1", req_ready); end
        model_ccr = 4'b0; model_cnt = '0;
    endtask

    task automatic test_same_edge_ccr;
        send(4'h7, 8'h10, 8'h05, 1'b1, 4'b0001);
        n_chk++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL lat_eval_valid got %b want 0", resp_valid); end
        tick();
        n_chk++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL lat_resp_valid got %b want 1", resp_valid); end
        e = sb.pop_front();
        n_chk++; if (resp_taken !== e.taken) begin n_fail++; $display("FAIL same_edge_taken got %b want %b", resp_taken, e.taken); end
        n_chk++; if (resp_target !== e.target) begin n_fail++; $display("FAIL same_edge_target got %h want %h", resp_target, e.target); end
        handshake();
        n_chk++; if (taken_cnt !== model_cnt) begin n_fail++; $display("FAIL same_edge_cnt got %0d want %0d", taken_cnt, model_cnt); end
    endtask

    task automatic test_neg_offset;
        bit ok;
        write_ccr(4'b0000);
        send(4'h6, 8'h10, 8'hFC, 1'b0, 4'b0);
        ccr_we = 1'b1; ccr_in = 4'b0001;
        tick();
        ccr_we = 1'b0; model_ccr = 4'b0001;
        wait_resp(ok);
        e = sb.pop_front();
        n_chk++; if (!ok) begin n_fail++; $display("FAIL neg_off_timeout got no resp_valid want 1"); end
        n_chk++; if (resp_taken !== e.taken) begin n_fail++; $display("FAIL neg_off_taken got %b want %b", resp_taken, e.taken); end
        n_chk++; if (resp_target !== e.target) begin n_fail++; $display("FAIL neg_off_target got %h want %h", resp_target, e.target); end
        n_chk++; if (ccr_out !== model_ccr) begin n_fail++; $display("FAIL neg_off_ccr got %b want %b", ccr_out, model_ccr); end
        handshake();
        n_chk++; if (taken_cnt !== model_cnt) begin n_fail++; $display("FAIL neg_off_cnt got %0d want %0d", taken_cnt, model_cnt); end
    endtask

    task automatic test_wrap_signed;
        logic [3:0]    ccrs  [6] = '{4'b1000, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0101};
        logic [3:0]    conds [6] = '{4'h4,    4'hC,    4'hD,    4'hE,    4'hF,    4'h2};
        logic [AW-1:0] pcs   [6] = '{8'hFF,   8'h30,   8'h31,   8'h32,   8'h33,   8'hF0};
        bit ok;
        for (int i = 0; i < 6; i++) begin
            write_ccr(ccrs[i]);
            send(conds[i], pcs[i], 8'h20, 1'b0, 4'b0);
            wait_resp(ok);
            e = sb.pop_front();
            n_chk++; if (!ok) begin n_fail++; $display("FAIL cond%0d_timeout got no resp_valid want 1", i); end
            n_chk++; if (resp_taken !== e.taken) begin n_fail++; $display("FAIL cond%0d_taken got %b want %b", i, resp_taken, e.taken); end
            n_chk++; if (resp_target !== e.target) begin n_fail++; $display("FAIL cond%0d_target got %h want %h", i, resp_target, e.target); end
            handshake();
            n_chk++; if (taken_cnt !== model_cnt) begin n_fail++; $display("FAIL cond%0d_cnt got %0d want %0d", i, taken_cnt, model_cnt); end
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        exp_t first;
        send(4'h0, 8'h20, 8'h03, 1'b0, 4'b0);
        wait_resp(ok);
        first = sb.pop_front();
        n_chk++; if (!ok) begin n_fail++; $display("FAIL bp_timeout got no resp_valid want 1"); end
        req_valid = 1'b1; req_cond = 4'h1; req_pc = 8'h40; req_off = 8'h10;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++;
            if (resp_valid !== 1'b1 || resp_taken !== first.taken || resp_target !== first.target || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d got v=%b t=%b tgt=%h rdy=%b want v=1 t=%b tgt=%h rdy=0",
                         i, resp_valid, resp_taken, resp_target, req_ready, first.taken, first.target);
            end
        end
        e = first;
        handshake();
        n_chk++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle got rdy=%b v=%b want rdy=1 v=0", req_ready, resp_valid); end
        sb.push_back(ref_resp(4'h1, model_ccr, 8'h40, 8'h10));
        tick();
        req_valid = 1'b0;
        wait_resp(ok);
        e = sb.pop_front();
        n_chk++; if (!ok) begin n_fail++; $display("FAIL bp_second_timeout got no resp_valid want 1"); end
        n_chk++; if (resp_taken !== e.taken || resp_target !== e.target) begin n_fail++; $display("FAIL bp_second got t=%b tgt=%h want t=%b tgt=%h", resp_taken, resp_target, e.taken, e.target); end
        handshake();
    endtask

    task automatic test_saturation_reset;
        bit ok;
        test_reset();
        for (int i = 0; i < 5; i++) begin
            send(4'h0, AW'(8'h50 + i), 8'h02, 1'b0, 4'b0);
            wait_resp(ok);
            e = sb.pop_front();
            n_chk++; if (!ok || resp_target !== e.target) begin n_fail++; $display("FAIL sat%0d_resp got ok=%b tgt=%h want tgt=%h", i, ok, resp_target, e.target); end
            handshake();
            n_chk++; if (taken_cnt !== model_cnt) begin n_fail++; $display("FAIL sat%0d_cnt got %0d want %0d", i, taken_cnt, model_cnt); end
        end
        n_chk++; if (taken_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_final got %0d want 3", taken_cnt); end
        write_ccr(4'b1111);
        send(4'h0, 8'h60, 8'h01, 1'b0, 4'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        model_ccr = 4'b0; model_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid%0d got %b want 0", i, resp_valid); end
            tick();
        end
        n_chk++; if (taken_cnt !== '0) begin n_fail++; $display("FAIL midrst_cnt got %0d want 0", taken_cnt); end
        n_chk++; if (ccr_out !== 4'b0) begin n_fail++; $display("FAIL midrst_ccr got %b want 0000", ccr_out); end
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b want 1", req_ready); end
    endtask

    initial begin
        rst_n = 1'b0; ccr_we = 1'b0; ccr_in = 4'b0; req_valid = 1'b0;
        req_cond = 4'b0; req_pc = '0; req_off = '0; resp_ready = 1'b0;
        e = '0;
        test_reset();
        test_same_edge_ccr();
        test_neg_offset();
        test_wrap_signed();
        test_backpressure();
        test_saturation_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
